// File: rtl/serial_nibble_rx.sv
// Serial nibble receiver: start, 4 data bits MSB first, optional even parity,
// stop; good frames land in a DEPTH-nibble FIFO. Optional: SERIAL_NIBBLE_RX_PARITY_EN.
// Ports: clk, reset (async low), bit_en, serial_in -> out_data/out_valid/out_ready,
// frame_err, parity_err (pulses), overflow (sticky), clr_err.
module serial_nibble_rx #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic       serial_in,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overflow,
  input  logic       clr_err
);

  localparam int AW = $clog2(DEPTH);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DATA, STOP
  } state_t;
`endif

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [3:0] shreg, shreg_n;
  logic       ferr_n;
  logic       push_req;

  logic [3:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic        full, pop, push_ok, drop;

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic perr, perr_n, perr_p_n;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    ferr_n   = 1'b0;
    push_req = 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    perr_n   = perr;
    perr_p_n = 1'b0;
`endif
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!serial_in) begin
            state_n = DATA;
            cnt_n   = 2'd0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            perr_n  = 1'b0;
`endif
          end
        end
        DATA: begin
          shreg_n = {shreg[2:0], serial_in};
          cnt_n   = cnt + 2'd1;
          if (cnt == 2'd3) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        PARITY: begin
          perr_n  = (^shreg) ^ serial_in;
          state_n = STOP;
        end
`endif
        STOP: begin
          state_n = IDLE;
          if (!serial_in) begin
            ferr_n = 1'b1;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
          end else if (perr) begin
            perr_p_n = 1'b1;
`endif
          end else begin
            push_req = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      shreg     <= 4'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
    end
  end

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr       <= perr_n;
      parity_err <= perr_p_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // A full buffer still takes a push when the head leaves on the same edge.
  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Directed bench for serial_nibble_rx.
// Works with or without SERIAL_NIBBLE_RX_PARITY_EN.
module tb_serial_nibble_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_en = 1'b1;
  logic       serial_in = 1'b1;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err;
  logic       parity_err;
  logic       overflow;
  logic       clr_err = 1'b0;

  int pass_cnt = 0;
  int total = 0;

  serial_nibble_rx #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en),
    .serial_in(serial_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .overflow(overflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] nib, input logic stop_b,
                            input logic par_ok, input logic rdy_stop);
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(nib[i]);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    send_bit((^nib) ^ ~par_ok);
`endif
    if (rdy_stop) out_ready = 1'b1;
    send_bit(stop_b);
    if (rdy_stop) out_ready = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (out_data !== 4'h0) $display("FAIL rst_data got %h exp 0", out_data); else pass_cnt++;
    total++; if (frame_err !== 1'b0) $display("FAIL rst_ferr got %b exp 0", frame_err); else pass_cnt++;
    total++; if (parity_err !== 1'b0) $display("FAIL rst_perr got %b exp 0", parity_err); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_early got %b exp 0", out_valid); else pass_cnt++;
    send_bit(1'b0);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    send_bit(1'b0);
`endif
    total++; if (out_valid !== 1'b0) $display("FAIL basic_prestop got %b exp 0", out_valid); else pass_cnt++;
    send_bit(1'b1);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 4'hA) $display("FAIL basic_data got %h exp a", out_data); else pass_cnt++;
    total++; if (frame_err !== 1'b0) $display("FAIL basic_ferr got %b exp 0", frame_err); else pass_cnt++;
    send_bit(1'b1);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_onecyc got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    out_ready = 1'b1;
    send_frame(4'hC, 1'b0, 1'b1, 1'b0);
    total++; if (frame_err !== 1'b1) $display("FAIL ferr_pulse got %b exp 1", frame_err); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL ferr_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (parity_err !== 1'b0) $display("FAIL ferr_perr got %b exp 0", parity_err); else pass_cnt++;
    send_bit(1'b1);
    total++; if (frame_err !== 1'b0) $display("FAIL ferr_once got %b exp 0", frame_err); else pass_cnt++;
    send_frame(4'h3, 1'b1, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL ferr_next_valid got %b exp 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 4'h3) $display("FAIL ferr_next_data got %h exp 3", out_data); else pass_cnt++;
    send_bit(1'b1);
  endtask

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  task automatic test_parity;
    out_ready = 1'b1;
    send_frame(4'h7, 1'b1, 1'b0, 1'b0);
    total++; if (parity_err !== 1'b1) $display("FAIL par_pulse got %b exp 1", parity_err); else pass_cnt++;
    total++; if (frame_err !== 1'b0) $display("FAIL par_ferr got %b exp 0", frame_err); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL par_valid got %b exp 0", out_valid); else pass_cnt++;
    send_bit(1'b1);
    total++; if (parity_err !== 1'b0) $display("FAIL par_once got %b exp 0", parity_err); else pass_cnt++;
  endtask
`endif

  task automatic test_overflow;
    logic [3:0] exp_q [4];
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(4'(i), 1'b1, 1'b1, 1'b0);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_pre got %b exp 0", overflow); else pass_cnt++;
    send_frame(4'h5, 1'b1, 1'b1, 1'b0);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else pass_cnt++;
    send_bit(1'b1);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else pass_cnt++;
    clr_err = 1'b1;
    send_bit(1'b1);
    clr_err = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", overflow); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== exp_q[i] || out_valid !== 1'b1)
        $display("FAIL ovf_drain%0d got %h/%b exp %h/1", i, out_data, out_valid, exp_q[i]);
      else pass_cnt++;
      send_bit(1'b1);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL ovf_empty got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_full_pop;
    logic [3:0] exp_q [4];
    exp_q = '{4'h6, 4'h7, 4'h8, 4'h9};
    out_ready = 1'b0;
    for (int i = 5; i <= 8; i++) send_frame(4'(i), 1'b1, 1'b1, 1'b0);
    total++; if (out_data !== 4'h5) $display("FAIL fp_head got %h exp 5", out_data); else pass_cnt++;
    send_frame(4'h9, 1'b1, 1'b1, 1'b1);
    total++; if (overflow !== 1'b0) $display("FAIL fp_ovf got %b exp 0", overflow); else pass_cnt++;
    total++; if (out_data !== 4'h6) $display("FAIL fp_newhead got %h exp 6", out_data); else pass_cnt++;
    send_bit(1'b1);
    total++; if (out_data !== 4'h6) $display("FAIL fp_hold got %h exp 6", out_data); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== exp_q[i] || out_valid !== 1'b1)
        $display("FAIL fp_drain%0d got %h/%b exp %h/1", i, out_data, out_valid, exp_q[i]);
      else pass_cnt++;
      send_bit(1'b1);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL fp_empty got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    #2;
    total++; if (frame_err !== 1'b0 || parity_err !== 1'b0)
      $display("FAIL mid_err got %b%b exp 00", frame_err, parity_err);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    send_bit(1'b1);
    send_frame(4'h6, 1'b1, 1'b1, 1'b0);
    total++; if (frame_err !== 1'b0 || parity_err !== 1'b0)
      $display("FAIL mid_post_err got %b%b exp 00", frame_err, parity_err);
    else pass_cnt++;
    total++; if (out_valid !== 1'b1) $display("FAIL mid_valid got %b exp 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 4'h6) $display("FAIL mid_data got %h exp 6", out_data); else pass_cnt++;
    send_bit(1'b1);
    total++; if (out_data !== 4'h6) $display("FAIL mid_hold got %h exp 6", out_data); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_frame_err;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    test_parity;
`endif
    test_overflow;
    test_full_pop;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
